// File: rtl/MIDI.sv
// MIDI message and note-change types shared by the decoder, dispatcher and pipelines.
// Exports message_t, note_change_t, ON/OFF and the controller numbers used here.
package MIDI;

    typedef enum logic [1:0] {
        NOTE_OFF       = 2'd0,
        NOTE_ON        = 2'd1,
        CONTROL_CHANGE = 2'd2
    } message_type_t;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } note_state_t;

    localparam logic [6:0] CC_SUSTAIN       = 7'd64;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef struct packed {
        message_type_t message_type;
        logic [3:0]    channel;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    typedef struct packed {
        note_state_t state;
        logic [6:0]  note_number;
        logic [6:0]  velocity;
    } note_change_t;

endpackage

// File: rtl/note_dispatcher_pkg.sv
// Voice table entry and age helpers for note_dispatcher.
// The sustained flag only exists when SUSTAIN_PEDAL_EN is defined.
package note_dispatcher_pkg;

    // Widest age counter supported; AGE_WIDTH must not exceed this.
    localparam int VOICE_AGE_W = 16;

    typedef struct packed {
        logic                   active;
`ifdef SUSTAIN_PEDAL_EN
        logic                   sustained;
`endif
        logic [6:0]             note_number;
        logic [VOICE_AGE_W-1:0] age;
    } voice_t;

    function automatic logic [VOICE_AGE_W-1:0] age_inc(
        input logic [VOICE_AGE_W-1:0] age,
        input logic [VOICE_AGE_W-1:0] age_max
    );
        if (age >= age_max)
            return age_max;
        return age + {{(VOICE_AGE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/voice_allocator.sv
// Combinational search over the voice table: same-note match, lowest free voice,
// oldest sustained voice (SUSTAIN_PEDAL_EN) and oldest active voice.
// Ports: voices (table), note_number (query), match_hit/match_idx, alloc_idx, alloc_steal.
module voice_allocator
    import note_dispatcher_pkg::*;
#(
    parameter int PIPELINE_COUNT = 4,
    localparam int IDX_W = (PIPELINE_COUNT > 1) ? $clog2(PIPELINE_COUNT) : 1
) (
    input  voice_t [PIPELINE_COUNT-1:0] voices,
    input  logic [6:0]                  note_number,
    output logic                        match_hit,
    output logic [IDX_W-1:0]            match_idx,
    output logic [IDX_W-1:0]            alloc_idx,
    output logic                        alloc_steal
);

    logic                   free_hit;
    logic [IDX_W-1:0]       free_idx;
    logic                   old_hit;
    logic [IDX_W-1:0]       old_idx;
    logic [VOICE_AGE_W-1:0] old_age;
`ifdef SUSTAIN_PEDAL_EN
    logic                   sus_hit;
    logic [IDX_W-1:0]       sus_idx;
    logic [VOICE_AGE_W-1:0] sus_age;
`endif

    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        old_hit   = 1'b0;
        old_idx   = '0;
        old_age   = '0;
`ifdef SUSTAIN_PEDAL_EN
        sus_hit   = 1'b0;
        sus_idx   = '0;
        sus_age   = '0;
`endif
        // Strict '>' keeps the lowest index on an age tie.
        for (int i = 0; i < PIPELINE_COUNT; i++) begin
            if (voices[i].active) begin
                if (!match_hit && voices[i].note_number == note_number) begin
                    match_hit = 1'b1;
                    match_idx = IDX_W'(i);
                end
                if (!old_hit || voices[i].age > old_age) begin
                    old_hit = 1'b1;
                    old_idx = IDX_W'(i);
                    old_age = voices[i].age;
                end
`ifdef SUSTAIN_PEDAL_EN
                if (voices[i].sustained && (!sus_hit || voices[i].age > sus_age)) begin
                    sus_hit = 1'b1;
                    sus_idx = IDX_W'(i);
                    sus_age = voices[i].age;
                end
`endif
            end else if (!free_hit) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alloc_idx   = old_idx;
        alloc_steal = 1'b1;
        if (match_hit) begin
            alloc_idx   = match_idx;
            alloc_steal = 1'b0;
        end else if (free_hit) begin
            alloc_idx   = free_idx;
            alloc_steal = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        end else if (sus_hit) begin
            alloc_idx   = sus_idx;
            alloc_steal = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/note_dispatcher.sv
// Turns decoded MIDI messages into registered per-pipeline note changes with channel
// filtering, retrigger and oldest-voice stealing. Optional macro: SUSTAIN_PEDAL_EN.
// Ports: clock_50_000_000, reset (async, high), listen_channel, omni_en, message,
// message_ready in; pipeline_notes, pipeline_notes_ready, voices_active, voice_stolen out.
module note_dispatcher
    import MIDI::*;
    import note_dispatcher_pkg::*;
#(
    parameter int PIPELINE_COUNT = 4,
    parameter int AGE_WIDTH      = 8
) (
    input  logic                              clock_50_000_000,
    input  logic                              reset,
    input  logic [3:0]                        listen_channel,
    input  logic                              omni_en,
    input  MIDI::message_t                    message,
    input  logic                              message_ready,
    output MIDI::note_change_t [PIPELINE_COUNT-1:0] pipeline_notes,
    output logic [PIPELINE_COUNT-1:0]         pipeline_notes_ready,
    output logic [PIPELINE_COUNT-1:0]         voices_active,
    output logic                              voice_stolen
);

    localparam int IDX_W = (PIPELINE_COUNT > 1) ? $clog2(PIPELINE_COUNT) : 1;
    localparam logic [VOICE_AGE_W-1:0] AGE_MAX = VOICE_AGE_W'((1 << AGE_WIDTH) - 1);

    voice_t [PIPELINE_COUNT-1:0]       voices_q;
    voice_t [PIPELINE_COUNT-1:0]       voices_d;
    note_change_t [PIPELINE_COUNT-1:0] notes_d;
    logic [PIPELINE_COUNT-1:0]         ready_d;
    logic                              stolen_d;
`ifdef SUSTAIN_PEDAL_EN
    logic                              sustain_q;
    logic                              sustain_d;
`endif

    logic             accept;
    logic             is_on;
    logic             is_off;
    logic             is_cc;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_steal;

    assign accept = message_ready &
                    (omni_en | (message.channel == listen_channel));
    // Velocity-0 NOTE_ON is a NOTE_OFF in disguise.
    assign is_on  = (message.message_type == NOTE_ON) && (message.data_byte2 != 7'd0);
    assign is_off = (message.message_type == NOTE_OFF) ||
                    ((message.message_type == NOTE_ON) && (message.data_byte2 == 7'd0));
    assign is_cc  = (message.message_type == CONTROL_CHANGE);

    voice_allocator #(
        .PIPELINE_COUNT(PIPELINE_COUNT)
    ) u_alloc (
        .voices      (voices_q),
        .note_number (message.data_byte1),
        .match_hit   (match_hit),
        .match_idx   (match_idx),
        .alloc_idx   (alloc_idx),
        .alloc_steal (alloc_steal)
    );

    always_comb begin
        voices_d  = voices_q;
        notes_d   = pipeline_notes;
        ready_d   = '0;
        stolen_d  = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        sustain_d = sustain_q;
`endif
        if (accept) begin
            unique case (1'b1)
                is_on: begin
                    for (int i = 0; i < PIPELINE_COUNT; i++) begin
                        if (IDX_W'(i) == alloc_idx) begin
                            voices_d[i].active      = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
                            voices_d[i].sustained   = 1'b0;
`endif
                            voices_d[i].note_number = message.data_byte1;
                            voices_d[i].age         = '0;
                            notes_d[i] = '{state: ON,
                                           note_number: message.data_byte1,
                                           velocity: message.data_byte2};
                            ready_d[i] = 1'b1;
                        end else if (voices_q[i].active) begin
                            voices_d[i].age = age_inc(voices_q[i].age, AGE_MAX);
                        end
                    end
                    stolen_d = alloc_steal;
                end
                is_off: begin
                    for (int i = 0; i < PIPELINE_COUNT; i++) begin
                        if (match_hit && IDX_W'(i) == match_idx) begin
`ifdef SUSTAIN_PEDAL_EN
                            if (sustain_q) begin
                                voices_d[i].sustained = 1'b1;
                            end else begin
                                voices_d[i].active = 1'b0;
                                notes_d[i] = '{state: OFF,
                                               note_number: voices_q[i].note_number,
                                               velocity: message.data_byte2};
                                ready_d[i] = 1'b1;
                            end
`else
                            voices_d[i].active = 1'b0;
                            notes_d[i] = '{state: OFF,
                                           note_number: voices_q[i].note_number,
                                           velocity: message.data_byte2};
                            ready_d[i] = 1'b1;
`endif
                        end
                    end
                end
                is_cc: begin
                    if (message.data_byte1 == CC_ALL_NOTES_OFF) begin
                        for (int i = 0; i < PIPELINE_COUNT; i++) begin
                            if (voices_q[i].active) begin
                                voices_d[i].active = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
                                voices_d[i].sustained = 1'b0;
`endif
                                notes_d[i] = '{state: OFF,
                                               note_number: voices_q[i].note_number,
                                               velocity: 7'd0};
                                ready_d[i] = 1'b1;
                            end
                        end
`ifdef SUSTAIN_PEDAL_EN
                    end else if (message.data_byte1 == CC_SUSTAIN) begin
                        // Bit 6 set means value >= 64.
                        sustain_d = message.data_byte2[6];
                        if (!message.data_byte2[6]) begin
                            for (int i = 0; i < PIPELINE_COUNT; i++) begin
                                if (voices_q[i].active && voices_q[i].sustained) begin
                                    voices_d[i].active    = 1'b0;
                                    voices_d[i].sustained = 1'b0;
                                    notes_d[i] = '{state: OFF,
                                                   note_number: voices_q[i].note_number,
                                                   velocity: 7'd0};
                                    ready_d[i] = 1'b1;
                                end
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            voices_q             <= '0;
            pipeline_notes       <= '0;
            pipeline_notes_ready <= '0;
            voice_stolen         <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
            sustain_q            <= 1'b0;
`endif
        end else begin
            voices_q             <= voices_d;
            pipeline_notes       <= notes_d;
            pipeline_notes_ready <= ready_d;
            voice_stolen         <= stolen_d;
`ifdef SUSTAIN_PEDAL_EN
            sustain_q            <= sustain_d;
`endif
        end
    end

    always_comb begin
        voices_active = '0;
        for (int i = 0; i < PIPELINE_COUNT; i++)
            voices_active[i] = voices_q[i].active;
    end

endmodule

// File: tb/tb_note_dispatcher.sv
// Directed vector bench for note_dispatcher (4 voices) plus a 1-voice instance.
// Sustain sequences are included when SUSTAIN_PEDAL_EN is defined.
module tb_note_dispatcher;
    import MIDI::*;

    typedef struct {
        message_type_t typ;
        logic [3:0]    ch;
        logic [6:0]    d1;
        logic [6:0]    d2;
        logic          omni;
        logic [3:0]    listen;
        logic [3:0]    exp_ready;
        logic [3:0]    exp_active;
        logic          exp_stolen;
        int            idx;
        note_state_t   exp_state;
        logic [6:0]    exp_note;
        logic [6:0]    exp_vel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] listen;
    logic omni;
    message_t msg;
    logic msg_ready;
    note_change_t [3:0] notes;
    logic [3:0] ready;
    logic [3:0] active;
    logic stolen;
    note_change_t [0:0] notes1;
    logic [0:0] ready1;
    logic [0:0] active1;
    logic stolen1;

    int applied = 0;
    int errors  = 0;
    vec_t vecs[21];

    always #5 clk = ~clk;

    note_dispatcher #(.PIPELINE_COUNT(4), .AGE_WIDTH(8)) u_dut (
        .clock_50_000_000     (clk),
        .reset                (rst),
        .listen_channel       (listen),
        .omni_en              (omni),
        .message              (msg),
        .message_ready        (msg_ready),
        .pipeline_notes       (notes),
        .pipeline_notes_ready (ready),
        .voices_active        (active),
        .voice_stolen         (stolen)
    );

    note_dispatcher #(.PIPELINE_COUNT(1), .AGE_WIDTH(8)) u_one (
        .clock_50_000_000     (clk),
        .reset                (rst),
        .listen_channel       (listen),
        .omni_en              (omni),
        .message              (msg),
        .message_ready        (msg_ready),
        .pipeline_notes       (notes1),
        .pipeline_notes_ready (ready1),
        .voices_active        (active1),
        .voice_stolen         (stolen1)
    );

    function automatic vec_t mk(message_type_t t, logic [3:0] c, logic [6:0] a,
                                logic [6:0] b, logic om, logic [3:0] li,
                                logic [3:0] er, logic [3:0] ea, logic es, int ix,
                                note_state_t st, logic [6:0] n, logic [6:0] v);
        vec_t r;
        r.typ = t; r.ch = c; r.d1 = a; r.d2 = b; r.omni = om; r.listen = li;
        r.exp_ready = er; r.exp_active = ea; r.exp_stolen = es; r.idx = ix;
        r.exp_state = st; r.exp_note = n; r.exp_vel = v;
        return r;
    endfunction

    task automatic drive(message_type_t t, logic [3:0] c, logic [6:0] a,
                         logic [6:0] b, logic om, logic [3:0] li);
        msg.message_type = t;
        msg.channel      = c;
        msg.data_byte1   = a;
        msg.data_byte2   = b;
        omni             = om;
        listen           = li;
        msg_ready        = 1'b1;
    endtask

    task automatic check(string name, logic [3:0] er, logic [3:0] ea, logic es,
                         int ix, note_state_t st, logic [6:0] n, logic [6:0] v);
        note_change_t exp_n;
        exp_n = '{state: st, note_number: n, velocity: v};
        applied++;
        if (ready !== er || active !== ea || stolen !== es || notes[ix] !== exp_n) begin
            errors++;
            $display("FAIL %s: ready=%b active=%b stolen=%b note[%0d]=%h, expected ready=%b active=%b stolen=%b note=%h",
                     name, ready, active, stolen, ix, notes[ix], er, ea, es, exp_n);
        end
    endtask

    task automatic check1(string name, logic er, logic ea, logic es,
                          note_state_t st, logic [6:0] n, logic [6:0] v);
        note_change_t exp_n;
        exp_n = '{state: st, note_number: n, velocity: v};
        applied++;
        if (ready1 !== er || active1 !== ea || stolen1 !== es || notes1[0] !== exp_n) begin
            errors++;
            $display("FAIL %s: ready=%b active=%b stolen=%b note=%h, expected ready=%b active=%b stolen=%b note=%h",
                     name, ready1, active1, stolen1, notes1[0], er, ea, es, exp_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(NOTE_ON,  0, 60, 100, 0, 0, 4'b0001, 4'b0001, 0, 0, ON,  60, 100);
        vecs[1]  = mk(NOTE_ON,  0, 62,  90, 0, 0, 4'b0010, 4'b0011, 0, 1, ON,  62,  90);
        vecs[2]  = mk(NOTE_ON,  0, 64,  80, 0, 0, 4'b0100, 4'b0111, 0, 2, ON,  64,  80);
        vecs[3]  = mk(NOTE_ON,  0, 65,  70, 0, 0, 4'b1000, 4'b1111, 0, 3, ON,  65,  70);
        vecs[4]  = mk(NOTE_ON,  0, 67,  50, 0, 0, 4'b0001, 4'b1111, 1, 0, ON,  67,  50);
        vecs[5]  = mk(NOTE_ON,  0, 62, 127, 0, 0, 4'b0010, 4'b1111, 0, 1, ON,  62, 127);
        vecs[6]  = mk(NOTE_ON,  0, 70,  10, 0, 0, 4'b0100, 4'b1111, 1, 2, ON,  70,  10);
        vecs[7]  = mk(NOTE_OFF, 0, 65,  33, 0, 0, 4'b1000, 4'b0111, 0, 3, OFF, 65,  33);
        vecs[8]  = mk(NOTE_OFF, 0, 61,  40, 0, 0, 4'b0000, 4'b0111, 0, 3, OFF, 65,  33);
        vecs[9]  = mk(NOTE_ON,  3, 61,  20, 0, 0, 4'b0000, 4'b0111, 0, 3, OFF, 65,  33);
        vecs[10] = mk(NOTE_ON,  3, 61,  20, 1, 0, 4'b1000, 4'b1111, 0, 3, ON,  61,  20);
        vecs[11] = mk(NOTE_ON,  5, 67,   0, 0, 5, 4'b0001, 4'b1110, 0, 0, OFF, 67,   0);
        vecs[12] = mk(CONTROL_CHANGE, 0, 123, 0, 0, 0, 4'b1110, 4'b0000, 0, 2, OFF, 70, 0);
        vecs[13] = mk(NOTE_OFF, 0, 70,   0, 0, 0, 4'b0000, 4'b0000, 0, 2, OFF, 70,   0);
        vecs[14] = mk(CONTROL_CHANGE, 0, 64, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, OFF, 70, 0);
        vecs[15] = mk(NOTE_ON,  0, 60, 100, 0, 0, 4'b0001, 4'b0001, 0, 0, ON,  60, 100);
        vecs[16] = mk(NOTE_ON,  0, 60,   0, 0, 0, 4'b0001, 4'b0000, 0, 0, OFF, 60,   0);
        vecs[17] = mk(NOTE_ON,  0, 40,  11, 0, 0, 4'b0001, 4'b0001, 0, 0, ON,  40,  11);
        vecs[18] = mk(NOTE_ON,  0, 41,  12, 0, 0, 4'b0010, 4'b0011, 0, 1, ON,  41,  12);
        vecs[19] = mk(NOTE_ON,  0, 42,  13, 0, 0, 4'b0100, 4'b0111, 0, 2, ON,  42,  13);
        vecs[20] = mk(CONTROL_CHANGE, 0, 123, 0, 0, 0, 4'b0111, 4'b0000, 0, 1, OFF, 41, 0);

        rst = 1'b1;
        msg = '0;
        msg_ready = 1'b0;
        listen = 4'd0;
        omni = 1'b0;
        repeat (2) step();
        check("reset", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].typ, vecs[i].ch, vecs[i].d1, vecs[i].d2,
                  vecs[i].omni, vecs[i].listen);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_active,
                  vecs[i].exp_stolen, vecs[i].idx, vecs[i].exp_state,
                  vecs[i].exp_note, vecs[i].exp_vel);
        end

        // Back-to-back: second message must see the voice set up by the first.
        drive(NOTE_ON, 0, 50, 9, 0, 0);
        step();
        check("b2b_on", 4'b0001, 4'b0001, 0, 0, ON, 50, 9);
        drive(NOTE_OFF, 0, 50, 5, 0, 0);
        step();
        check("b2b_off", 4'b0001, 4'b0000, 0, 0, OFF, 50, 5);

        // Asynchronous reset mid-hold: cleared at once, no OFF afterwards.
        drive(NOTE_ON, 0, 33, 90, 0, 0);
        step();
        check("hold33", 4'b0001, 4'b0001, 0, 0, ON, 33, 90);
        msg_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);
        #2 rst = 1'b0;
        step();
        check("post_rst", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);

`ifdef SUSTAIN_PEDAL_EN
        drive(CONTROL_CHANGE, 0, 64, 127, 0, 0);
        step();
        check("ped_down", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);
        drive(NOTE_ON, 0, 60, 100, 0, 0);
        step();
        check("sus_on60", 4'b0001, 4'b0001, 0, 0, ON, 60, 100);
        drive(NOTE_OFF, 0, 60, 0, 0, 0);
        step();
        check("sus_off60", 4'b0000, 4'b0001, 0, 0, ON, 60, 100);
        drive(NOTE_ON, 0, 62, 5, 0, 0);
        step();
        check("sus_on62", 4'b0010, 4'b0011, 0, 1, ON, 62, 5);
        drive(NOTE_ON, 0, 60, 80, 0, 0);
        step();
        check("sus_retrig", 4'b0001, 4'b0011, 0, 0, ON, 60, 80);
        drive(NOTE_OFF, 0, 62, 0, 0, 0);
        step();
        check("sus_off62", 4'b0000, 4'b0011, 0, 1, ON, 62, 5);
        drive(CONTROL_CHANGE, 0, 64, 0, 0, 0);
        step();
        check("ped_up", 4'b0010, 4'b0001, 0, 1, OFF, 62, 0);
        drive(NOTE_OFF, 0, 60, 3, 0, 0);
        step();
        check("off60", 4'b0001, 4'b0000, 0, 0, OFF, 60, 3);
        drive(CONTROL_CHANGE, 0, 64, 100, 0, 0);
        step();
        drive(NOTE_ON, 0, 60, 100, 0, 0);
        step();
        drive(NOTE_OFF, 0, 60, 0, 0, 0);
        step();
        check("sus_hold", 4'b0000, 4'b0001, 0, 0, ON, 60, 100);
        msg_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check("sus_rst", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);
        #2 rst = 1'b0;
        drive(CONTROL_CHANGE, 0, 64, 0, 0, 0);
        step();
        check("ped_up_rst", 4'b0000, 4'b0000, 0, 0, OFF, 0, 0);
        msg_ready = 1'b0;
        step();
`endif

        // Single-voice instance: every new note lands on voice 0.
        drive(NOTE_ON, 0, 60, 100, 0, 0);
        step();
        check1("one_on60", 1'b1, 1'b1, 1'b0, ON, 60, 100);
        drive(NOTE_ON, 0, 62, 50, 0, 0);
        step();
        check1("one_steal", 1'b1, 1'b1, 1'b1, ON, 62, 50);
        drive(NOTE_ON, 0, 62, 7, 0, 0);
        step();
        check1("one_retrig", 1'b1, 1'b1, 1'b0, ON, 62, 7);
        drive(NOTE_OFF, 0, 62, 9, 0, 0);
        step();
        check1("one_off", 1'b1, 1'b0, 1'b0, OFF, 62, 9);
        msg_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
